// File: rtl/camera_gpio_pio.sv
// camera_gpio_pio
// Avalon-MM bidirectional GPIO for camera/LCD control pins. Each bit has its
// own tristate direction, outputs support atomic set/clear, and inputs pass
// through a synchroniser into an edge detector that feeds a maskable,
// level-sensitive interrupt. Writes need no wait states; reads are registered.
module camera_gpio_pio #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter logic [31:0] RESET_OUT   = 32'h0,
  parameter logic [31:0] RESET_DIR   = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  inout  wire  [WIDTH-1:0]  bidir_port
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;

  // Upper writedata bits beyond WIDTH have no destination.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr    = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  // Pads are driven only where the direction bit selects output.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
  end

  // Output data register: plain write, atomic set and atomic clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT[WIDTH-1:0];
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_out <= wdata;
        ADDR_OUTSET: data_out <= data_out | wdata;
        ADDR_OUTCLR: data_out <= data_out & ~wdata;
        default:     data_out <= data_out;
      endcase
    end
  end

  // Direction and interrupt mask registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir      <= RESET_DIR[WIDTH-1:0];
      irq_mask <= '0;
    end else if (wr) begin
      if (address == ADDR_DIR)     dir      <= wdata;
      if (address == ADDR_IRQMASK) irq_mask <= wdata;
    end
  end

  // Input synchroniser chain plus one extra flop holding the previous value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= bidir_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

  // Select which transitions count as events.
  always_comb begin
    ev = rise | fall;
    if (EDGE_TYPE == 0)      ev = rise;
    else if (EDGE_TYPE == 1) ev = fall;
  end

  assign edge_clr = (wr && address == ADDR_EDGE) ? wdata : '0;

  // Edge capture with write-one-to-clear; a fresh edge beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cap <= '0;
    else          edge_cap <= ev | (edge_cap & ~edge_clr);
  end

  // Registered level interrupt from enabled captured edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(edge_cap & irq_mask);
  end

  // Read multiplexer; unimplemented bits and addresses return zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = s;
      ADDR_DIR:     rd_mux[WIDTH-1:0] = dir;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE:    rd_mux[WIDTH-1:0] = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  // Read data register, updated every cycle without side effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule
